// File: rtl/ctrl_pkg.sv
// ctrl_pkg: encodings shared between the multicycle control FSM and the
// datapath multiplexers of the multicycle RV32I core.
//   state_t       control FSM states
//   OP_*          RV32I major opcodes recognised by the decoder
//   alu_op_t      alu_op field sent to the ALU control decoder
//   src_a_t       ALU operand A select
//   src_b_t       ALU operand B select
//   result_src_t  result bus select
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXEC_R  = 4'd6,
    S_EXEC_I  = 4'd7,
    S_ALU_WB  = 4'd8,
    S_BRANCH  = 4'd9,
    S_JAL     = 4'd10,
    S_TRAP    = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_RTYPE = 2'b10,
    ALU_ITYPE = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    SRC_A_PC    = 2'b00,
    SRC_A_OLDPC = 2'b01,
    SRC_A_RS1   = 2'b10
  } src_a_t;

  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'b00,
    SRC_B_IMM  = 2'b01,
    SRC_B_FOUR = 2'b10
  } src_b_t;

  typedef enum logic [1:0] {
    RES_ALUOUT  = 2'b00,
    RES_MEMDATA = 2'b01,
    RES_ALU     = 2'b10
  } result_src_t;

  // Only beq (000) and bne (001) are implemented; other branches trap.
  function automatic logic branch_supported(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001);
  endfunction

endpackage

// File: rtl/ctrl_perf_counters.sv
// ctrl_perf_counters: free-running cycle and retired-instruction counters
// for the multicycle control unit. Both wrap modulo 2^CNT_W.
//   clk      in   clock
//   rst      in   synchronous active-high reset (clears both counters)
//   retire   in   one instruction retires this cycle
//   cycles   out  non-reset cycles since reset (0 while rst is high)
//   instret  out  retired instructions since reset (0 while rst is high)
module ctrl_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             retire,
  output logic [CNT_W-1:0] cycles,
  output logic [CNT_W-1:0] instret
);

  logic [CNT_W-1:0] cycles_r;
  logic [CNT_W-1:0] instret_r;

  // Counter registers: cycles every non-reset cycle, instret on retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycles_r  <= {CNT_W{1'b0}};
      instret_r <= {CNT_W{1'b0}};
    end else begin
      cycles_r <= cycles_r + {{(CNT_W-1){1'b0}}, 1'b1};
      if (retire) begin
        instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        instret_r <= instret_r;
      end
    end
  end

  // Outputs read as zero during the reset cycle like every other control output.
  assign cycles  = rst ? {CNT_W{1'b0}} : cycles_r;
  assign instret = rst ? {CNT_W{1'b0}} : instret_r;

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing the shared ALU, register file and
// unified memory port of the multicycle RV32I core
// (fetch / decode / execute / writeback).
// Optional feature macro: CTRL_PERF_EN (cycles/instret counters). Without it
// the counter ports exist but are tied to zero.
//   clk, rst                        clock, synchronous active-high reset
//   opcode, funct3                  instruction fields from IR
//   zero                            ALU zero flag (same cycle)
//   mem_ready                       memory completes the current request
//   mem_req, mem_we, adr_src        memory request, write qualifier, address select
//   ir_write, pc_write, reg_write   IR/oldPC, PC and register-file write enables
//   alu_src_a, alu_src_b, alu_op    ALU operand selects and ALU control op
//   result_src                      result bus select
//   illegal                         trap flag (sticky until rst)
//   cycles, instret                 perf counters (CNT_W bits)
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_src,
  output logic             illegal,
  output logic [CNT_W-1:0] cycles,
  output logic [CNT_W-1:0] instret
);

  state_t      state_r;
  state_t      next_s;
  logic        mem_req_s;
  logic        mem_we_s;
  logic        adr_src_s;
  logic        ir_write_s;
  logic        pc_write_s;
  logic        reg_write_s;
  src_a_t      src_a_s;
  src_b_t      src_b_s;
  alu_op_t     alu_op_s;
  result_src_t result_src_s;
  logic        illegal_s;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state and state-decoded outputs; everything not set in a state is 0.
  always_comb begin
    next_s       = state_r;
    mem_req_s    = 1'b0;
    mem_we_s     = 1'b0;
    adr_src_s    = 1'b0;
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    src_a_s      = SRC_A_PC;
    src_b_s      = SRC_B_RS2;
    alu_op_s     = ALU_ADD;
    result_src_s = RES_ALUOUT;
    illegal_s    = 1'b0;
    case (state_r)
      S_FETCH: begin
        // PC+4 goes straight to the PC as the fetch completes.
        mem_req_s    = 1'b1;
        src_b_s      = SRC_B_FOUR;
        result_src_s = RES_ALU;
        ir_write_s   = mem_ready;
        pc_write_s   = mem_ready;
        if (mem_ready) begin
          next_s = S_DECODE;
        end else begin
          next_s = S_FETCH;
        end
      end
      S_DECODE: begin
        // Precompute the branch/jump target into ALUOut.
        src_a_s = SRC_A_OLDPC;
        src_b_s = SRC_B_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: next_s = S_MEM_ADR;
          OP_R:              next_s = S_EXEC_R;
          OP_I:              next_s = S_EXEC_I;
          OP_BRANCH: begin
            if (branch_supported(funct3)) begin
              next_s = S_BRANCH;
            end else begin
              next_s = S_TRAP;
            end
          end
          OP_JAL:            next_s = S_JAL;
          default:           next_s = S_TRAP;
        endcase
      end
      S_MEM_ADR: begin
        src_a_s = SRC_A_RS1;
        src_b_s = SRC_B_IMM;
        // opcode[5] separates store (0100011) from load (0000011).
        if (opcode[5]) begin
          next_s = S_MEM_WR;
        end else begin
          next_s = S_MEM_RD;
        end
      end
      S_MEM_RD: begin
        mem_req_s = 1'b1;
        adr_src_s = 1'b1;
        if (mem_ready) begin
          next_s = S_MEM_WB;
        end else begin
          next_s = S_MEM_RD;
        end
      end
      S_MEM_WB: begin
        reg_write_s  = 1'b1;
        result_src_s = RES_MEMDATA;
        next_s       = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req_s = 1'b1;
        mem_we_s  = 1'b1;
        adr_src_s = 1'b1;
        if (mem_ready) begin
          next_s = S_FETCH;
        end else begin
          next_s = S_MEM_WR;
        end
      end
      S_EXEC_R: begin
        src_a_s  = SRC_A_RS1;
        src_b_s  = SRC_B_RS2;
        alu_op_s = ALU_RTYPE;
        next_s   = S_ALU_WB;
      end
      S_EXEC_I: begin
        src_a_s  = SRC_A_RS1;
        src_b_s  = SRC_B_IMM;
        alu_op_s = ALU_ITYPE;
        next_s   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_s  = 1'b1;
        result_src_s = RES_ALUOUT;
        next_s       = S_FETCH;
      end
      S_BRANCH: begin
        // beq takes on zero, bne on !zero: funct3[0] inverts the sense.
        src_a_s      = SRC_A_RS1;
        src_b_s      = SRC_B_RS2;
        alu_op_s     = ALU_SUB;
        result_src_s = RES_ALUOUT;
        pc_write_s   = zero ^ funct3[0];
        next_s       = S_FETCH;
      end
      S_JAL: begin
        // Jump to the target in ALUOut while the ALU forms oldPC+4 for rd.
        src_a_s      = SRC_A_OLDPC;
        src_b_s      = SRC_B_FOUR;
        alu_op_s     = ALU_ADD;
        result_src_s = RES_ALUOUT;
        pc_write_s   = 1'b1;
        next_s       = S_ALU_WB;
      end
      S_TRAP: begin
        illegal_s = 1'b1;
        next_s    = S_TRAP;
      end
      default: begin
        next_s = S_FETCH;
      end
    endcase
  end

  // Every output is forced low during the reset cycle, whatever the state.
  assign mem_req    = mem_req_s & ~rst;
  assign mem_we     = mem_we_s & ~rst;
  assign adr_src    = adr_src_s & ~rst;
  assign ir_write   = ir_write_s & ~rst;
  assign pc_write   = pc_write_s & ~rst;
  assign reg_write  = reg_write_s & ~rst;
  assign alu_src_a  = rst ? 2'b00 : src_a_s;
  assign alu_src_b  = rst ? 2'b00 : src_b_s;
  assign alu_op     = rst ? 2'b00 : alu_op_s;
  assign result_src = rst ? 2'b00 : result_src_s;
  assign illegal    = illegal_s & ~rst;

`ifdef CTRL_PERF_EN
  logic retire_s;

  // Retire points: both writebacks, branch resolution, completed store.
  assign retire_s = (state_r == S_MEM_WB) || (state_r == S_ALU_WB) ||
                    (state_r == S_BRANCH) || ((state_r == S_MEM_WR) && mem_ready);

  ctrl_perf_counters #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk     (clk),
    .rst     (rst),
    .retire  (retire_s),
    .cycles  (cycles),
    .instret (instret)
  );
`else
  assign cycles  = {CNT_W{1'b0}};
  assign instret = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a directed table measuring per-instruction
// latency and write-enable counts, hand sequences for wait states, trap and
// mid-operation reset, and random instruction streams checked cycle by cycle
// against an instruction-level expectation model.
module tb_multicycle_control;

  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_R      = 7'b0110011;
  localparam logic [6:0] T_I      = 7'b0010011;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_JAL    = 7'b1101111;

  // Output vector: {req,we,adr,irw,pcw,rw,src_a,src_b,alu_op,result_src,illegal}
  localparam logic [14:0] V_FETCH_WAIT = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b10,1'b0};
  localparam logic [14:0] V_FETCH_GO   = {1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b10,2'b00,2'b10,1'b0};
  localparam logic [14:0] V_DECODE     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,2'b00,2'b00,1'b0};
  localparam logic [14:0] V_MADR       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,2'b00,1'b0};
  localparam logic [14:0] V_MEMRD      = {1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0};
  localparam logic [14:0] V_MEMWB      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b01,1'b0};
  localparam logic [14:0] V_MEMWR      = {1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0};
  localparam logic [14:0] V_EXR        = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,2'b00,1'b0};
  localparam logic [14:0] V_EXI        = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b11,2'b00,1'b0};
  localparam logic [14:0] V_ALUWB      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,1'b0};
  localparam logic [14:0] V_JAL        = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b01,2'b10,2'b00,2'b00,1'b0};
  localparam logic [14:0] V_TRAP       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b1};
  localparam logic [14:0] V_ZERO       = 15'd0;

  logic        clk;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, illegal;
  logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
  logic [31:0] cycles, instret;
  logic [14:0] act;

  int vectors;
  int miscompares;

  multicycle_control #(.CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct3     (funct3),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .result_src (result_src),
    .illegal    (illegal),
    .cycles     (cycles),
    .instret    (instret)
  );

  assign act = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, alu_op, result_src, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // One clock cycle: drive at posedge+1, compare at negedge, return at next posedge+1.
  task automatic step(input logic mr, input logic z, input logic [14:0] e, input string nm);
    mem_ready = mr;
    zero      = z;
    @(negedge clk);
    chk(nm, {17'd0, act}, {17'd0, e});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    mem_ready = 1'b1;
    zero      = 1'b1;
    @(negedge clk);
    chk("rst_outputs", {17'd0, act}, 32'd0);
    chk("rst_cycles", cycles, 32'd0);
    chk("rst_instret", instret, 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    mem_ready = 1'b0;
  endtask

  // Instruction-level model: expands one instruction into its expected
  // per-cycle output sequence and checks it; unused inputs are randomised.
  task automatic run_model(input logic [6:0] op, input logic [2:0] f3, input logic z,
                           input int fw, input int mw, output logic trapped);
    logic        taken;
    logic [14:0] brv;
    opcode  = op;
    funct3  = f3;
    trapped = 1'b0;
    for (int i = 0; i < fw; i++) step(1'b0, rb(), V_FETCH_WAIT, "fetch_wait");
    step(1'b1, rb(), V_FETCH_GO, "fetch");
    step(rb(), rb(), V_DECODE, "decode");
    if (op == T_LOAD) begin
      step(rb(), rb(), V_MADR, "ld_mem_adr");
      for (int i = 0; i < mw; i++) step(1'b0, rb(), V_MEMRD, "mem_rd_wait");
      step(1'b1, rb(), V_MEMRD, "mem_rd");
      step(rb(), rb(), V_MEMWB, "mem_wb");
    end else if (op == T_STORE) begin
      step(rb(), rb(), V_MADR, "st_mem_adr");
      for (int i = 0; i < mw; i++) step(1'b0, rb(), V_MEMWR, "mem_wr_wait");
      step(1'b1, rb(), V_MEMWR, "mem_wr");
    end else if (op == T_R) begin
      step(rb(), rb(), V_EXR, "exec_r");
      step(rb(), rb(), V_ALUWB, "r_alu_wb");
    end else if (op == T_I) begin
      step(rb(), rb(), V_EXI, "exec_i");
      step(rb(), rb(), V_ALUWB, "i_alu_wb");
    end else if (op == T_BRANCH && (f3 == 3'd0 || f3 == 3'd1)) begin
      taken = (f3 == 3'd0) ? z : !z;
      brv   = {1'b0,1'b0,1'b0,1'b0,taken,1'b0,2'b10,2'b00,2'b01,2'b00,1'b0};
      step(rb(), z, brv, "branch");
    end else if (op == T_JAL) begin
      step(rb(), rb(), V_JAL, "jal");
      step(rb(), rb(), V_ALUWB, "jal_alu_wb");
    end else begin
      trapped = 1'b1;
      for (int i = 0; i < 3; i++) step(rb(), rb(), V_TRAP, "trap");
    end
  endtask

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       z;
    int         exp_len;  // cycles until next fetch; 0 = never returns (trap)
    int         exp_rw;   // cycles with reg_write high
    int         exp_pcw;  // cycles with pc_write high, including the fetch
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic       trapped;
    logic [6:0] op;
    logic [2:0] f3;
    int         len, rwc, pcc, sel;

    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    opcode      = T_R;
    funct3      = 3'd0;
    zero        = 1'b0;
    mem_ready   = 1'b0;

    tbl[0]  = '{"add",      T_R,         3'd0, 1'b0, 4, 1, 1};
    tbl[1]  = '{"addi",     T_I,         3'd0, 1'b0, 4, 1, 1};
    tbl[2]  = '{"lw",       T_LOAD,      3'd2, 1'b0, 5, 1, 1};
    tbl[3]  = '{"sw",       T_STORE,     3'd2, 1'b0, 4, 0, 1};
    tbl[4]  = '{"beq_z1",   T_BRANCH,    3'd0, 1'b1, 3, 0, 2};
    tbl[5]  = '{"beq_z0",   T_BRANCH,    3'd0, 1'b0, 3, 0, 1};
    tbl[6]  = '{"bne_z1",   T_BRANCH,    3'd1, 1'b1, 3, 0, 1};
    tbl[7]  = '{"bne_z0",   T_BRANCH,    3'd1, 1'b0, 3, 0, 2};
    tbl[8]  = '{"jal",      T_JAL,       3'd0, 1'b0, 4, 1, 2};
    tbl[9]  = '{"blt_trap", T_BRANCH,    3'd4, 1'b1, 0, 0, 1};
    tbl[10] = '{"op0_trap", 7'b0000000,  3'd0, 1'b0, 0, 0, 1};

    @(posedge clk);
    @(posedge clk);
    #1;

    // Directed table: latency and enable counts measured on the DUT.
    foreach (tbl[k]) begin
      do_reset();
      opcode    = tbl[k].op;
      funct3    = tbl[k].f3;
      zero      = tbl[k].z;
      mem_ready = 1'b1;
      len = 0; rwc = 0; pcc = 0;
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        if (c > 0 && mem_req && !adr_src && alu_src_b == 2'b10) begin
          len = c;
          break;
        end
        rwc += int'(reg_write);
        pcc += int'(pc_write);
        @(posedge clk);
        #1;
      end
      chk({tbl[k].name, "_len"}, len, tbl[k].exp_len);
      chk({tbl[k].name, "_reg_write"}, rwc, tbl[k].exp_rw);
      chk({tbl[k].name, "_pc_write"}, pcc, tbl[k].exp_pcw);
      chk({tbl[k].name, "_illegal"}, {31'd0, illegal}, {31'd0, (tbl[k].exp_len == 0)});
      if (len != 0) begin
        @(posedge clk);
        #1;
      end
    end

    // lw with three wait states: mem_req held four cycles in MEM_RD.
    do_reset();
    run_model(T_LOAD, 3'd2, 1'b0, 0, 3, trapped);

    // Illegal opcode: trap absorbs for 20 cycles, then reset recovers.
    do_reset();
    opcode = 7'b0000000;
    step(1'b1, 1'b0, V_FETCH_GO, "trap_fetch");
    step(1'b1, 1'b0, V_DECODE, "trap_decode");
    for (int i = 0; i < 20; i++) step(rb(), rb(), V_TRAP, "trap_hold");
    do_reset();
    step(1'b0, 1'b0, V_FETCH_WAIT, "post_trap_fetch");

    // Reset while a store is waiting on memory.
    do_reset();
    opcode = T_STORE;
    step(1'b1, 1'b0, V_FETCH_GO, "sw_fetch");
    step(1'b0, 1'b0, V_DECODE, "sw_decode");
    step(1'b0, 1'b0, V_MADR, "sw_mem_adr");
    step(1'b0, 1'b0, V_MEMWR, "sw_mem_wr_wait");
    rst = 1'b1;
    step(1'b0, 1'b0, V_ZERO, "rst_in_mem_wr");
    rst = 1'b0;
    step(1'b0, 1'b0, V_FETCH_WAIT, "fetch_after_rst");

    // addi, sw, jal from reset with mem_ready=1.
    do_reset();
    run_model(T_I, 3'd0, 1'b0, 0, 0, trapped);
    run_model(T_STORE, 3'd2, 1'b0, 0, 0, trapped);
    run_model(T_JAL, 3'd0, 1'b0, 0, 0, trapped);
    step(1'b0, 1'b0, V_FETCH_WAIT, "perf_idle_fetch");
    @(negedge clk);
`ifdef CTRL_PERF_EN
    chk("perf_instret", instret, 32'd3);
    chk("perf_cycles", cycles, 32'd13);
`else
    chk("perf_instret_off", instret, 32'd0);
    chk("perf_cycles_off", cycles, 32'd0);
`endif
    @(posedge clk);
    #1;

    // Random instruction streams.
    do_reset();
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0: op = T_LOAD;
        1: op = T_STORE;
        2: op = T_R;
        3: op = T_I;
        4, 5: op = T_BRANCH;
        6: op = T_JAL;
        default: op = 7'($urandom_range(0, 127));
      endcase
      f3 = (op == T_BRANCH && $urandom_range(0, 3) != 0) ? 3'($urandom_range(0, 1))
                                                           : 3'($urandom_range(0, 7));
      run_model(op, f3, rb(), $urandom_range(0, 2), $urandom_range(0, 3), trapped);
      if (trapped) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
